// File: rtl/servo_pkg.sv
// Shared types, default timing constants and angle helpers for the servo PWM block.
package servo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } servo_state_t;

  localparam int unsigned DEF_PERIOD_CYCLES    = 32'd2_000_000;
  localparam int unsigned DEF_MIN_PULSE_CYCLES = 32'd50_000;
  localparam int unsigned DEF_CYCLES_PER_DEG   = 32'd1_000;
  localparam int unsigned DEF_MAX_ANGLE        = 32'd250;
  localparam int unsigned DEF_SLEW_STEP        = 32'd10;

  function automatic logic [8:0] clamp_angle(input logic [8:0] ang, input logic [8:0] max_ang);
    logic [8:0] res;
    if (ang > max_ang) begin
      res = max_ang;
    end else begin
      res = ang;
    end
    return res;
  endfunction

  // Moves cur toward tgt by at most step, never overshooting.
  function automatic logic [8:0] slew_toward(input logic [8:0] cur, input logic [8:0] tgt,
                                             input logic [8:0] step);
    logic [8:0] diff;
    logic [8:0] res;
    if (tgt >= cur) begin
      diff = tgt - cur;
      res  = (diff > step) ? (cur + step) : tgt;
    end else begin
      diff = cur - tgt;
      res  = (diff > step) ? (cur - step) : tgt;
    end
    return res;
  endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// Frame counter for the servo PWM: counts clocks within a frame, flags the last
// clock of the frame and strobes the first clock of each new frame.
module servo_frame_timer
  import servo_pkg::*;
#(
  parameter int unsigned PERIOD_CYCLES = DEF_PERIOD_CYCLES
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_start,
  input  logic        i_run,
  output logic [31:0] o_count,
  output logic        o_wrap,
  output logic        o_frame_start
);

  logic [31:0] r_count;
  logic        r_frame_start;

  assign o_wrap        = (r_count == (PERIOD_CYCLES - 32'd1));
  assign o_count       = r_count;
  assign o_frame_start = r_frame_start;

  // Counter restarts on a frame start, advances while running, and parks at zero otherwise.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count       <= 32'd0;
      r_frame_start <= 1'b0;
    end else if (i_start) begin
      r_count       <= 32'd0;
      r_frame_start <= 1'b1;
    end else if (i_run && !o_wrap) begin
      r_count       <= r_count + 32'd1;
      r_frame_start <= 1'b0;
    end else begin
      r_count       <= 32'd0;
      r_frame_start <= 1'b0;
    end
  end

endmodule

// File: rtl/servo_pwm_generator.sv
// Servo PWM generator: frame FSM with per-frame angle latching, slew limiting
// and a registered pulse output; frame timing lives in servo_frame_timer.
module servo_pwm_generator
  import servo_pkg::*;
#(
  parameter int unsigned CLK_HZ           = 32'd100_000_000,
  parameter int unsigned PERIOD_CYCLES    = DEF_PERIOD_CYCLES,
  parameter int unsigned MIN_PULSE_CYCLES = DEF_MIN_PULSE_CYCLES,
  parameter int unsigned CYCLES_PER_DEG   = DEF_CYCLES_PER_DEG,
  parameter int unsigned MAX_ANGLE        = DEF_MAX_ANGLE,
  parameter int unsigned SLEW_STEP        = DEF_SLEW_STEP
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic [8:0] angle,
  output logic       pwm,
  output logic [8:0] applied_angle,
  output logic       frame_start,
  output logic       settled
);

  localparam logic [8:0] MAX_A  = 9'(MAX_ANGLE);
  localparam logic [8:0] STEP_A = 9'(SLEW_STEP);

  if ((SLEW_STEP < 32'd1) || (CLK_HZ == 32'd0)) begin : g_bad_params
    $error("servo_pwm_generator: SLEW_STEP must be at least 1 and CLK_HZ nonzero");
  end

  servo_state_t r_state;
  logic         r_start_req;
  logic         r_pwm;
  logic         r_settled;
  logic [8:0]   r_applied;
  logic [8:0]   r_target;

  logic [31:0]  w_count;
  logic [31:0]  w_next_count;
  logic [31:0]  w_pulse_cycles;
  logic [8:0]   w_clamped;
  logic [8:0]   w_next_applied;
  logic         w_wrap;
  logic         w_start;
  logic         w_run;
  logic         w_frame_start;

  assign w_clamped      = clamp_angle(angle, MAX_A);
  assign w_next_applied = slew_toward(r_applied, w_clamped, STEP_A);
  assign w_pulse_cycles = 32'(MIN_PULSE_CYCLES) + (32'(r_applied) * 32'(CYCLES_PER_DEG));
  assign w_next_count   = w_count + 32'd1;
  assign w_run          = (r_state != ST_IDLE);
  // From IDLE a frame starts one clock after enable is seen; otherwise back-to-back at wrap.
  assign w_start        = (r_state == ST_IDLE) ? r_start_req : (w_wrap & enable);

  servo_frame_timer #(
    .PERIOD_CYCLES (PERIOD_CYCLES)
  ) u_frame_timer (
    .clk           (clk),
    .resetn        (resetn),
    .i_start       (w_start),
    .i_run         (w_run),
    .o_count       (w_count),
    .o_wrap        (w_wrap),
    .o_frame_start (w_frame_start)
  );

  // Frame FSM: latch target and slew at frame start, then shape the pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_start_req <= 1'b0;
      r_pwm       <= 1'b0;
      r_applied   <= 9'd0;
      r_target    <= 9'd0;
      r_settled   <= 1'b1;
    end else begin
      r_start_req <= (r_state == ST_IDLE) && enable && !w_start;
      if (w_start) begin
        r_state   <= ST_HIGH;
        r_pwm     <= 1'b1;
        r_target  <= w_clamped;
        r_applied <= w_next_applied;
        r_settled <= (w_next_applied == w_clamped);
      end else begin
        r_settled <= (r_applied == r_target);
        case (r_state)
          ST_IDLE: begin
            r_pwm <= 1'b0;
          end
          ST_HIGH: begin
            if (w_wrap) begin
              r_state <= ST_IDLE;
              r_pwm   <= 1'b0;
            end else if (w_next_count >= w_pulse_cycles) begin
              r_state <= ST_LOW;
              r_pwm   <= 1'b0;
            end else begin
              r_pwm <= 1'b1;
            end
          end
          ST_LOW: begin
            r_pwm <= 1'b0;
            if (w_wrap) begin
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_LOW;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_pwm   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pwm           = r_pwm;
  assign applied_angle = r_applied;
  assign frame_start   = w_frame_start;
  assign settled       = r_settled;

endmodule

// File: tb/tb_servo_pwm_generator.sv
// Scoreboard bench for servo_pwm_generator: per-frame expectations come from a
// slew/clamp model and are compared against measured frames.
module tb_servo_pwm_generator;

  localparam int PERIOD = 1000;
  localparam int MINP   = 100;
  localparam int CPD    = 2;
  localparam int MAXA   = 250;
  localparam int STEP   = 10;

  logic       clk;
  logic       resetn;
  logic       enable;
  logic [8:0] angle;
  logic       pwm;
  logic [8:0] applied_angle;
  logic       frame_start;
  logic       settled;

  typedef struct {
    int app;
    int high;
    int stl;
  } exp_t;

  exp_t q[$];
  int   n_total;
  int   n_bad;
  int   m_app;

  servo_pwm_generator #(
    .PERIOD_CYCLES    (PERIOD),
    .MIN_PULSE_CYCLES (MINP),
    .CYCLES_PER_DEG   (CPD),
    .MAX_ANGLE        (MAXA),
    .SLEW_STEP        (STEP)
  ) u_dut (
    .clk           (clk),
    .resetn        (resetn),
    .enable        (enable),
    .angle         (angle),
    .pwm           (pwm),
    .applied_angle (applied_angle),
    .frame_start   (frame_start),
    .settled       (settled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int want);
    n_total++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  // Model of one frame start latching angle a.
  task automatic push_exp(input int a);
    exp_t e;
    int   tgt;
    int   pw;
    tgt = (a > MAXA) ? MAXA : a;
    if (tgt > m_app) m_app = m_app + (((tgt - m_app) > STEP) ? STEP : (tgt - m_app));
    else             m_app = m_app - (((m_app - tgt) > STEP) ? STEP : (m_app - tgt));
    pw     = MINP + m_app * CPD;
    e.app  = m_app;
    e.high = (pw >= PERIOD) ? PERIOD : pw;
    e.stl  = (m_app == tgt) ? 1 : 0;
    q.push_back(e);
  endtask

  task automatic wait_fs();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 1200);
    if (!frame_start) check_eq("fs_timeout", 0, 1);
  endtask

  // Set the angle for the next frame (optionally toggling it during this one).
  task automatic step(input int a, input bit toggle);
    if (toggle) begin
      for (int i = 0; i < 16; i++) begin
        repeat (50) @(negedge clk);
        angle = (i % 2 == 1) ? 9'd0 : 9'd220;
      end
    end
    angle = 9'(a);
    push_exp(a);
    wait_fs();
  endtask

  // Frame monitor: measures each frame and scores it against the queue.
  initial begin : mon
    int   high;
    int   anom;
    int   app;
    int   stl;
    bit   aborted;
    logic prev;
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn && frame_start) begin
        app     = int'(applied_angle);
        stl     = int'(settled);
        high    = pwm ? 1 : 0;
        prev    = pwm;
        anom    = pwm ? 0 : 1;
        aborted = 1'b0;
        for (int i = 1; i < PERIOD; i++) begin
          @(negedge clk);
          if (!resetn) begin
            aborted = 1'b1;
            break;
          end
          if (pwm) high++;
          if (pwm && !prev) anom++;
          if (frame_start) anom++;
          prev = pwm;
        end
        if (!aborted) begin
          if (q.size() == 0) begin
            check_eq("unexpected_frame", 1, 0);
          end else begin
            e = q.pop_front();
            check_eq("applied", app, e.app);
            check_eq("high_len", high, e.high);
            check_eq("settled", stl, e.stl);
            check_eq("shape", anom, 0);
          end
        end
      end
    end
  end

  initial begin : stim
    int quiet;
    int n;
    n_total = 0;
    n_bad   = 0;
    m_app   = 0;
    resetn  = 1'b0;
    enable  = 1'b0;
    angle   = 9'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_pwm", int'(pwm), 0);
    check_eq("rst_fs", int'(frame_start), 0);
    check_eq("rst_applied", int'(applied_angle), 0);
    check_eq("rst_settled", int'(settled), 1);
    resetn = 1'b1;
    @(negedge clk);
    check_eq("idle_pwm", int'(pwm), 0);

    push_exp(0);
    enable = 1'b1;
    @(negedge clk);
    check_eq("lat_n_fs", int'(frame_start), 0);
    @(negedge clk);
    check_eq("lat_n1_fs", int'(frame_start), 1);
    check_eq("lat_n1_pwm", int'(pwm), 1);

    for (int k = 0; k < 23; k++) step(220, 1'b0);
    step(220, 1'b1);
    for (int k = 0; k < 4; k++) step(400, 1'b0);

    // Drop enable mid-frame; the frame must still run to completion.
    repeat (50) @(negedge clk);
    enable = 1'b0;
    repeat (PERIOD - 50) @(negedge clk);
    check_eq("drop_end_pwm", int'(pwm), 0);
    check_eq("drop_end_fs", int'(frame_start), 0);
    quiet = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (pwm || frame_start) quiet++;
    end
    check_eq("idle_quiet", quiet, 0);

    angle = 9'd240;
    push_exp(240);
    enable = 1'b1;
    wait_fs();
    angle = 9'd100;
    wait_fs();
    repeat (20) @(negedge clk);
    check_eq("pre_rst_pwm", int'(pwm), 1);
    resetn = 1'b0;
    #1;
    check_eq("async_pwm", int'(pwm), 0);
    check_eq("async_applied", int'(applied_angle), 0);
    check_eq("async_fs", int'(frame_start), 0);
    check_eq("async_settled", int'(settled), 1);
    m_app = 0;
    repeat (5) @(negedge clk);
    push_exp(100);
    resetn = 1'b1;
    @(negedge clk);
    check_eq("restart_n_fs", int'(frame_start), 0);
    check_eq("restart_n_pwm", int'(pwm), 0);
    @(negedge clk);
    check_eq("restart_n1_fs", int'(frame_start), 1);
    check_eq("restart_n1_applied", int'(applied_angle), 10);
    enable = 1'b0;

    n = 0;
    while (q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
